reg_file_sb: RTL and testbench

Parametrised integer register file with write-to-read bypass and a per-register busy scoreboard for the in-order pipeline.
- Two combinational read ports, one synchronous write port.
- Decode allocates a destination register, which marks it busy. Writeback releases it. The block flags RAW hazards to the stall logic.
- A flush input drops all pending allocations on redirect/trap.
- A non-bypassed debug read port serves the debug module.

---
 rtl/reg_file_sb_if.sv | 55 +++++
 rtl/reg_file_sb.sv | 137 +++++++++++++
 tb/tb_reg_file_sb.sv | 258 +++++++++++++++++++++++++
 3 files changed

// File: rtl/reg_file_sb_if.sv
`default_nettype none
// ============================================================================
//  Module   : reg_file_sb_if
//  Purpose  : Decode/writeback/debug signal bundle of the scoreboarded
//             register file. The pipeline side is the master, the register
//             file is the slave.
//  Revision : 1.0 - initial release
// ============================================================================
interface reg_file_sb_if #(
    parameter int XLEN = 32,
    parameter int AW   = 5
);
    // Decode read side
    logic [AW-1:0]   rs1_addr_i;
    logic [AW-1:0]   rs2_addr_i;
    logic            rs1_use_i;
    logic            rs2_use_i;
    logic [XLEN-1:0] rs1_data_o;
    logic [XLEN-1:0] rs2_data_o;
    logic            rs1_busy_o;
    logic            rs2_busy_o;
    logic            hazard_o;
    // Destination allocation
    logic            alloc_en_i;
    logic [AW-1:0]   alloc_addr_i;
    // Writeback
    logic            rd_wr_en_i;
    logic [AW-1:0]   rd_addr_i;
    logic [XLEN-1:0] rd_data_i;
    // Redirect / trap
    logic            flush_i;
    // Debug and status
    logic [AW-1:0]   dbg_addr_i;
    logic [XLEN-1:0] dbg_data_o;
    logic [AW:0]     busy_cnt_o;

    modport master (
        output rs1_addr_i, rs2_addr_i, rs1_use_i, rs2_use_i,
        output alloc_en_i, alloc_addr_i,
        output rd_wr_en_i, rd_addr_i, rd_data_i,
        output flush_i, dbg_addr_i,
        input  rs1_data_o, rs2_data_o, rs1_busy_o, rs2_busy_o, hazard_o,
        input  dbg_data_o, busy_cnt_o
    );

    modport slave (
        input  rs1_addr_i, rs2_addr_i, rs1_use_i, rs2_use_i,
        input  alloc_en_i, alloc_addr_i,
        input  rd_wr_en_i, rd_addr_i, rd_data_i,
        input  flush_i, dbg_addr_i,
        output rs1_data_o, rs2_data_o, rs1_busy_o, rs2_busy_o, hazard_o,
        output dbg_data_o, busy_cnt_o
    );
endinterface
`default_nettype wire

// File: rtl/reg_file_sb.sv
`default_nettype none
// ============================================================================
//  Module   : reg_file_sb
//  Purpose  : Integer register file with two combinational read ports, one
//             synchronous write port, optional write-to-read bypass and a
//             per-register busy scoreboard that raises RAW hazards.
//  Revision : 1.0 - initial release
// ============================================================================
module reg_file_sb #(
    parameter int XLEN     = 32,
    parameter int AW       = 5,
    parameter int BYPASS   = 1,
    parameter int ZERO_REG = 1
) (
    input  wire logic     clk,
    input  wire logic     rst_n,
    reg_file_sb_if.slave  bus
);

    localparam int NREGS = 2 ** AW;

    logic [XLEN-1:0]  regs_q [NREGS];
    logic [NREGS-1:0] busy_q;
    logic [NREGS-1:0] busy_d;
    logic [AW:0]      busy_cnt_q;
    logic [AW:0]      busy_cnt_d;

    // Effective write / allocate strobes: register 0 is untouchable when hardwired
    logic w_wr_en;
    logic w_alloc_en;
    assign w_wr_en    = bus.rd_wr_en_i &&
                        !((ZERO_REG != 0) && (bus.rd_addr_i == '0));
    assign w_alloc_en = bus.alloc_en_i && !bus.flush_i &&
                        !((ZERO_REG != 0) && (bus.alloc_addr_i == '0));

    // Register array: cleared on reset, written on writeback
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < NREGS; i++) begin
                regs_q[i] <= '0;
            end
        end else if (w_wr_en) begin
            regs_q[bus.rd_addr_i] <= bus.rd_data_i;
        end
    end

    // Next busy vector: writeback releases, then flush clears or alloc sets
    // (alloc is applied last so it wins over a same-address writeback)
    always_comb begin
        busy_d = busy_q;
        if (w_wr_en) begin
            busy_d[bus.rd_addr_i] = 1'b0;
        end
        if (bus.flush_i) begin
            busy_d = '0;
        end else if (w_alloc_en) begin
            busy_d[bus.alloc_addr_i] = 1'b1;
        end
    end

    // Popcount of the next busy vector so the registered count tracks it exactly
    always_comb begin
        busy_cnt_d = '0;
        for (int i = 0; i < NREGS; i++) begin
            busy_cnt_d = busy_cnt_d + {{AW{1'b0}}, busy_d[i]};
        end
    end

    // Scoreboard state: busy bits and their count
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            busy_q     <= '0;
            busy_cnt_q <= '0;
        end else begin
            busy_q     <= busy_d;
            busy_cnt_q <= busy_cnt_d;
        end
    end

    // Read-port qualifiers: hardwired zero first, then same-cycle bypass
    logic w_rs1_zero;
    logic w_rs2_zero;
    logic w_dbg_zero;
    logic w_rs1_byp;
    logic w_rs2_byp;
    assign w_rs1_zero = (ZERO_REG != 0) && (bus.rs1_addr_i == '0);
    assign w_rs2_zero = (ZERO_REG != 0) && (bus.rs2_addr_i == '0);
    assign w_dbg_zero = (ZERO_REG != 0) && (bus.dbg_addr_i == '0);
    assign w_rs1_byp  = (BYPASS != 0) && bus.rd_wr_en_i &&
                        (bus.rd_addr_i == bus.rs1_addr_i);
    assign w_rs2_byp  = (BYPASS != 0) && bus.rd_wr_en_i &&
                        (bus.rd_addr_i == bus.rs2_addr_i);

    logic [XLEN-1:0] w_rs1_data;
    logic [XLEN-1:0] w_rs2_data;
    logic            w_rs1_busy;
    logic            w_rs2_busy;

    // Read port 1: a bypassed register is already resolved, so it is not busy
    always_comb begin
        w_rs1_data = regs_q[bus.rs1_addr_i];
        w_rs1_busy = busy_q[bus.rs1_addr_i];
        if (w_rs1_zero) begin
            w_rs1_data = '0;
            w_rs1_busy = 1'b0;
        end else if (w_rs1_byp) begin
            w_rs1_data = bus.rd_data_i;
            w_rs1_busy = 1'b0;
        end
    end

    // Read port 2: same rules as port 1
    always_comb begin
        w_rs2_data = regs_q[bus.rs2_addr_i];
        w_rs2_busy = busy_q[bus.rs2_addr_i];
        if (w_rs2_zero) begin
            w_rs2_data = '0;
            w_rs2_busy = 1'b0;
        end else if (w_rs2_byp) begin
            w_rs2_data = bus.rd_data_i;
            w_rs2_busy = 1'b0;
        end
    end

    assign bus.rs1_data_o = w_rs1_data;
    assign bus.rs2_data_o = w_rs2_data;
    assign bus.rs1_busy_o = w_rs1_busy;
    assign bus.rs2_busy_o = w_rs2_busy;
    assign bus.hazard_o   = (bus.rs1_use_i & w_rs1_busy) |
                            (bus.rs2_use_i & w_rs2_busy);

    // Debug port sees the architectural array only, never in-flight writeback
    assign bus.dbg_data_o = w_dbg_zero ? '0 : regs_q[bus.dbg_addr_i];
    assign bus.busy_cnt_o = busy_cnt_q;

endmodule
`default_nettype wire

// File: tb/tb_reg_file_sb.sv
`default_nettype none
// ============================================================================
//  Module   : tb_reg_file_sb
//  Purpose  : Self-checking bench for reg_file_sb. Drives a BYPASS=1 and a
//             BYPASS=0 instance with identical stimulus; directed table plus
//             randomized traffic against an array-based reference model.
//  Revision : 1.0 - initial release
// ============================================================================
module tb_reg_file_sb;

    logic clk;
    logic rst_n;

    reg_file_sb_if #(.XLEN(32), .AW(5)) bus ();
    reg_file_sb_if #(.XLEN(32), .AW(5)) bus_nb ();

    reg_file_sb #(.XLEN(32), .AW(5), .BYPASS(1), .ZERO_REG(1)) u_dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus.slave)
    );

    reg_file_sb #(.XLEN(32), .AW(5), .BYPASS(0), .ZERO_REG(1)) u_dut_nb (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus_nb.slave)
    );

    // The non-bypass instance mirrors every input of the main one
    assign bus_nb.rs1_addr_i   = bus.rs1_addr_i;
    assign bus_nb.rs2_addr_i   = bus.rs2_addr_i;
    assign bus_nb.rs1_use_i    = bus.rs1_use_i;
    assign bus_nb.rs2_use_i    = bus.rs2_use_i;
    assign bus_nb.alloc_en_i   = bus.alloc_en_i;
    assign bus_nb.alloc_addr_i = bus.alloc_addr_i;
    assign bus_nb.rd_wr_en_i   = bus.rd_wr_en_i;
    assign bus_nb.rd_addr_i    = bus.rd_addr_i;
    assign bus_nb.rd_data_i    = bus.rd_data_i;
    assign bus_nb.flush_i      = bus.flush_i;
    assign bus_nb.dbg_addr_i   = bus.dbg_addr_i;

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;

    task automatic chk(input string nm, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got=%0h exp=%0h at %0t", nm, got, exp, $time);
        end
    endtask

    // ---------------- reference model ----------------
    logic [31:0] m_regs [32];
    bit   [31:0] m_busy;

    task automatic m_reset();
        for (int i = 0; i < 32; i++) m_regs[i] = '0;
        m_busy = '0;
    endtask

    // Architectural effect of one rising edge, from the rules of the register file
    task automatic m_edge();
        if (bus.rd_wr_en_i && bus.rd_addr_i != 0) begin
            m_regs[bus.rd_addr_i] = bus.rd_data_i;
            m_busy[bus.rd_addr_i] = 1'b0;
        end
        if (bus.flush_i)
            m_busy = '0;
        else if (bus.alloc_en_i && bus.alloc_addr_i != 0)
            m_busy[bus.alloc_addr_i] = 1'b1;
    endtask

    function automatic logic [31:0] m_rd(input logic [4:0] a, input bit byp);
        if (a == 0) return '0;
        if (byp && bus.rd_wr_en_i && bus.rd_addr_i == a) return bus.rd_data_i;
        return m_regs[a];
    endfunction

    function automatic logic m_bsy(input logic [4:0] a, input bit byp);
        if (a == 0) return 1'b0;
        if (byp && bus.rd_wr_en_i && bus.rd_addr_i == a) return 1'b0;
        return m_busy[a];
    endfunction

    // ---------------- stimulus helpers ----------------
    task automatic apply(input logic [4:0] rs1, input logic [4:0] rs2,
                         input logic u1, input logic u2,
                         input logic al, input logic [4:0] aa,
                         input logic wr, input logic [4:0] wa, input logic [31:0] wd,
                         input logic fl, input logic [4:0] dbg);
        bus.rs1_addr_i   = rs1;
        bus.rs2_addr_i   = rs2;
        bus.rs1_use_i    = u1;
        bus.rs2_use_i    = u2;
        bus.alloc_en_i   = al;
        bus.alloc_addr_i = aa;
        bus.rd_wr_en_i   = wr;
        bus.rd_addr_i    = wa;
        bus.rd_data_i    = wd;
        bus.flush_i      = fl;
        bus.dbg_addr_i   = dbg;
    endtask

    task automatic tick();
        @(posedge clk);
        m_edge();
        #1;
    endtask

    typedef struct {
        logic [4:0]  rs1, rs2;
        logic        u1, u2, al;
        logic [4:0]  aa;
        logic        wr;
        logic [4:0]  wa;
        logic [31:0] wd;
        logic        fl;
        logic [4:0]  dbg;
        logic [31:0] e_d1, e_d2;
        logic        e_b1, e_haz;
        logic [31:0] e_dbg;
        logic [5:0]  e_cnt;
        logic        e_haznb;
        logic [31:0] e_d1nb;
    } vec_t;

    vec_t tbl [$];

    function automatic vec_t mk(
        input logic [4:0] rs1, input logic [4:0] rs2, input logic u1, input logic u2,
        input logic al, input logic [4:0] aa, input logic wr, input logic [4:0] wa,
        input logic [31:0] wd, input logic fl, input logic [4:0] dbg,
        input logic [31:0] e_d1, input logic [31:0] e_d2, input logic e_b1,
        input logic e_haz, input logic [31:0] e_dbg, input logic [5:0] e_cnt,
        input logic e_haznb, input logic [31:0] e_d1nb);
        vec_t v;
        v.rs1 = rs1; v.rs2 = rs2; v.u1 = u1; v.u2 = u2; v.al = al; v.aa = aa;
        v.wr = wr; v.wa = wa; v.wd = wd; v.fl = fl; v.dbg = dbg;
        v.e_d1 = e_d1; v.e_d2 = e_d2; v.e_b1 = e_b1; v.e_haz = e_haz;
        v.e_dbg = e_dbg; v.e_cnt = e_cnt; v.e_haznb = e_haznb; v.e_d1nb = e_d1nb;
        return v;
    endfunction

    initial begin
        // Directed sequence; expected values refer to outputs before each edge
        //               rs1 rs2 u1 u2 al aa  wr wa  wd            fl dbg  d1            d2 b1 hz dbg           cnt hzN d1N
        tbl.push_back(mk(0,  0,  0, 0, 0, 0,  0, 0,  32'h0,        0, 0,   32'h0,        0, 0, 0, 32'h0,        0, 0, 32'h0));
        tbl.push_back(mk(5,  0,  0, 0, 0, 0,  1, 5,  32'hDEADBEEF, 0, 5,   32'hDEADBEEF, 0, 0, 0, 32'h0,        0, 0, 32'h0));
        tbl.push_back(mk(5,  0,  1, 1, 1, 0,  1, 0,  32'h1234,     0, 5,   32'hDEADBEEF, 0, 0, 0, 32'hDEADBEEF, 0, 0, 32'hDEADBEEF));
        tbl.push_back(mk(7,  0,  1, 0, 1, 7,  0, 0,  32'h0,        0, 0,   32'h0,        0, 0, 0, 32'h0,        0, 0, 32'h0));
        tbl.push_back(mk(7,  0,  1, 0, 0, 0,  0, 0,  32'h0,        0, 7,   32'h0,        0, 1, 1, 32'h0,        1, 1, 32'h0));
        tbl.push_back(mk(7,  0,  0, 0, 0, 0,  0, 0,  32'h0,        0, 7,   32'h0,        0, 1, 0, 32'h0,        1, 0, 32'h0));
        tbl.push_back(mk(7,  0,  1, 0, 0, 0,  1, 7,  32'hA5A5A5A5, 0, 7,   32'hA5A5A5A5, 0, 0, 0, 32'h0,        1, 1, 32'h0));
        tbl.push_back(mk(7,  0,  1, 0, 0, 0,  0, 0,  32'h0,        0, 7,   32'hA5A5A5A5, 0, 0, 0, 32'hA5A5A5A5, 0, 0, 32'hA5A5A5A5));
        tbl.push_back(mk(3,  0,  0, 0, 1, 3,  0, 0,  32'h0,        0, 0,   32'h0,        0, 0, 0, 32'h0,        0, 0, 32'h0));
        tbl.push_back(mk(3,  0,  1, 0, 1, 4,  0, 0,  32'h0,        0, 0,   32'h0,        0, 1, 1, 32'h0,        1, 1, 32'h0));
        tbl.push_back(mk(4,  0,  1, 0, 1, 9,  0, 0,  32'h0,        0, 0,   32'h0,        0, 1, 1, 32'h0,        2, 1, 32'h0));
        tbl.push_back(mk(9,  0,  1, 0, 1, 10, 0, 0,  32'h0,        1, 0,   32'h0,        0, 1, 1, 32'h0,        3, 1, 32'h0));
        tbl.push_back(mk(10, 3,  1, 1, 0, 0,  0, 0,  32'h0,        0, 0,   32'h0,        0, 0, 0, 32'h0,        0, 0, 32'h0));
        tbl.push_back(mk(4,  0,  1, 0, 1, 4,  1, 4,  32'h44,       0, 4,   32'h44,       0, 0, 0, 32'h0,        0, 0, 32'h0));
        tbl.push_back(mk(4,  0,  1, 0, 0, 0,  0, 0,  32'h0,        0, 4,   32'h44,       0, 1, 1, 32'h44,       1, 1, 32'h44));

        // ---------------- reset and address sweep ----------------
        rst_n = 1'b0;
        apply(0, 0, 1, 1, 0, 0, 0, 0, 0, 0, 0);
        m_reset();
        #12;
        rst_n = 1'b1;
        for (int a = 0; a < 32; a++) begin
            bus.rs1_addr_i = 5'(a);
            bus.rs2_addr_i = 5'(31 - a);
            bus.dbg_addr_i = 5'(a);
            #1;
            chk("sweep_rs1", {32'h0, bus.rs1_data_o}, 64'h0);
            chk("sweep_rs2", {32'h0, bus.rs2_data_o}, 64'h0);
            chk("sweep_dbg", {32'h0, bus.dbg_data_o}, 64'h0);
            chk("sweep_haz", {63'h0, bus.hazard_o}, 64'h0);
        end
        chk("reset_cnt", {58'h0, bus.busy_cnt_o}, 64'h0);
        tick();

        // ---------------- directed table ----------------
        for (int i = 0; i < tbl.size(); i++) begin
            apply(tbl[i].rs1, tbl[i].rs2, tbl[i].u1, tbl[i].u2, tbl[i].al, tbl[i].aa,
                  tbl[i].wr, tbl[i].wa, tbl[i].wd, tbl[i].fl, tbl[i].dbg);
            #3;
            chk($sformatf("tbl%0d_d1", i),    {32'h0, bus.rs1_data_o},    {32'h0, tbl[i].e_d1});
            chk($sformatf("tbl%0d_d2", i),    {32'h0, bus.rs2_data_o},    {32'h0, tbl[i].e_d2});
            chk($sformatf("tbl%0d_b1", i),    {63'h0, bus.rs1_busy_o},    {63'h0, tbl[i].e_b1});
            chk($sformatf("tbl%0d_haz", i),   {63'h0, bus.hazard_o},      {63'h0, tbl[i].e_haz});
            chk($sformatf("tbl%0d_dbg", i),   {32'h0, bus.dbg_data_o},    {32'h0, tbl[i].e_dbg});
            chk($sformatf("tbl%0d_cnt", i),   {58'h0, bus.busy_cnt_o},    {58'h0, tbl[i].e_cnt});
            chk($sformatf("tbl%0d_hazNB", i), {63'h0, bus_nb.hazard_o},   {63'h0, tbl[i].e_haznb});
            chk($sformatf("tbl%0d_d1NB", i),  {32'h0, bus_nb.rs1_data_o}, {32'h0, tbl[i].e_d1nb});
            tick();
        end

        // ---------------- asynchronous reset mid-cycle ----------------
        apply(0, 0, 0, 0, 1, 8, 0, 0, 0, 0, 0);
        tick();
        apply(8, 4, 1, 1, 0, 0, 0, 0, 0, 0, 4);
        #1;
        chk("pre_rst_cnt", {58'h0, bus.busy_cnt_o}, 64'd2);
        chk("pre_rst_dbg", {32'h0, bus.dbg_data_o}, 64'h44);
        #1;
        rst_n = 1'b0;
        #1;
        m_reset();
        chk("arst_cnt",  {58'h0, bus.busy_cnt_o}, 64'h0);
        chk("arst_b1",   {63'h0, bus.rs1_busy_o}, 64'h0);
        chk("arst_haz",  {63'h0, bus.hazard_o},   64'h0);
        chk("arst_rs2",  {32'h0, bus.rs2_data_o}, 64'h0);
        chk("arst_dbg",  {32'h0, bus.dbg_data_o}, 64'h0);
        #1;
        rst_n = 1'b1;
        tick();

        // ---------------- randomized traffic vs model ----------------
        for (int n = 0; n < 3000; n++) begin
            logic [4:0]  r1, r2, aa, wa;
            logic [31:0] wd;
            r1 = 5'($urandom_range(0, 31));
            r2 = ($urandom_range(0, 7) == 0) ? r1 : 5'($urandom_range(0, 31));
            wa = ($urandom_range(0, 3) == 0) ? r1 : 5'($urandom_range(0, 31));
            aa = ($urandom_range(0, 5) == 0) ? wa : 5'($urandom_range(0, 31));
            wd = $urandom;
            apply(r1, r2, 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)),
                  1'($urandom_range(0, 1)), aa, 1'($urandom_range(0, 2) == 0), wa, wd,
                  1'($urandom_range(0, 40) == 0), 5'($urandom_range(0, 31)));
            #3;
            chk("rnd_d1",  {32'h0, bus.rs1_data_o}, {32'h0, m_rd(bus.rs1_addr_i, 1'b1)});
            chk("rnd_d2",  {32'h0, bus.rs2_data_o}, {32'h0, m_rd(bus.rs2_addr_i, 1'b1)});
            chk("rnd_b1",  {63'h0, bus.rs1_busy_o}, {63'h0, m_bsy(bus.rs1_addr_i, 1'b1)});
            chk("rnd_b2",  {63'h0, bus.rs2_busy_o}, {63'h0, m_bsy(bus.rs2_addr_i, 1'b1)});
            chk("rnd_haz", {63'h0, bus.hazard_o},
                {63'h0, (bus.rs1_use_i & m_bsy(bus.rs1_addr_i, 1'b1)) |
                        (bus.rs2_use_i & m_bsy(bus.rs2_addr_i, 1'b1))});
            chk("rnd_dbg", {32'h0, bus.dbg_data_o}, {32'h0, m_rd(bus.dbg_addr_i, 1'b0)});
            chk("rnd_cnt", {58'h0, bus.busy_cnt_o}, 64'($countones(m_busy)));
            chk("rnd_d1NB", {32'h0, bus_nb.rs1_data_o}, {32'h0, m_rd(bus.rs1_addr_i, 1'b0)});
            chk("rnd_d2NB", {32'h0, bus_nb.rs2_data_o}, {32'h0, m_rd(bus.rs2_addr_i, 1'b0)});
            chk("rnd_hazNB", {63'h0, bus_nb.hazard_o},
                {63'h0, (bus.rs1_use_i & m_bsy(bus.rs1_addr_i, 1'b0)) |
                        (bus.rs2_use_i & m_bsy(bus.rs2_addr_i, 1'b0))});
            chk("rnd_cntNB", {58'h0, bus_nb.busy_cnt_o}, 64'($countones(m_busy)));
            tick();
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
`default_nettype wire
